pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage pipeline around the instruction decoder.
- Consumes the decoded control bits after they are registered into ID/EX and EX/MEM (memread, memwrite, regwrite, branch), plus register indices.
- Drives stage write-enables, bubble insertion and flushes for three cases: load-use hazards, taken branches/jumps, and data-memory wait states.
- Sits beside the pipeline registers. Its outputs gate pc, IF/ID, ID/EX and EX/MEM.

Parameters:
- BRANCH_PENALTY, 2: cycles IF/ID is flushed after a taken branch in EX (1..7).
- MEM_TIMEOUT, 255: max consecutive wait cycles before mem_err sets (1..255).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  IF/ID holds a real instruction
- id_rs1  in  5  source reg 1 of instruction in ID
- id_rs2  in  5  source reg 2 of instruction in ID
- id_uses_rs2  in  1  instruction in ID reads rs2 (R-type, store, branch)
- ex_rd  in  5  destination reg of instruction in EX
- ex_memread  in  1  ID/EX memread control bit
- ex_branch_taken  in  1  EX branch bit AND condition true, or jal/jalr in EX
- mem_req  in  1  EX/MEM memread OR memwrite
- mem_ready  in  1  data memory completes this cycle
- pc_write  out  1  pc may update
- if_id_write  out  1  IF/ID may load
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_bubble  out  1  ID/EX control bits forced to 0
- ex_mem_hold  out  1  EX/MEM and MEM/WB hold
- mem_err  out  1  sticky memory-timeout flag
- state  out  2  0=RUN, 1=MEMW, 2=FLUSH

Behaviour:
- The FSM state, flush counter (3b), wait counter (8b) and mem_err are registered. All other outputs are combinational from the current state and inputs.
- While reset=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_mem_hold=0. On the next edge, state=RUN, counters=0, mem_err=0.
- Default outputs (no hazard): pc_write=1, if_id_write=1, flush=0, bubble=0, hold=0.
- Load-use condition lu: id_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
- Event priority, fixed: memory wait > taken branch > load-use.
- RUN:
  - If mem_req & !mem_ready: pc_write=0, if_id_write=0, ex_mem_hold=1, bubble=0. Next state MEMW, wait counter=1.
  - Else if ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1 (loads target). If BRANCH_PENALTY>1, next state FLUSH with flush counter=BRANCH_PENALTY-1; otherwise stay in RUN.
  - Else if lu: pc_write=0, if_id_write=0, id_ex_bubble=1. Stay in RUN. This is exactly one bubble, because the load advances to MEM.
- MEMW:
  - While !mem_ready: same freeze outputs as the RUN wait case; wait counter increments, saturating at 255.
  - If the counter reaches MEM_TIMEOUT, mem_err is set and stays set until reset. The freeze continues.
  - When mem_ready=1: default outputs this cycle; next state RUN; wait counter clears.
  - A taken branch or lu seen during MEMW is ignored. Inputs are frozen, so it is re-evaluated in RUN.
- FLUSH:
  - if_id_flush=1, id_ex_bubble=1, pc_write=1; flush counter decrements. When the counter reaches 1, next state is RUN.
  - If mem_req & !mem_ready arrives in FLUSH: freeze outputs plus if_id_flush=1. The flush counter holds, and the state stays FLUSH until mem_ready, then decrementing resumes.
  - A new ex_branch_taken in FLUSH reloads the counter to BRANCH_PENALTY-1.
- Reset mid-MEMW or mid-FLUSH aborts the operation immediately. No pending flush survives reset.
- Unused state encoding 3 → next state RUN, default outputs.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined: adds output stall_cycles (16b), counting cycles with pc_write=0 and reset=0, saturating at 16'hFFFF. Also adds output flush_events (16b), incremented once per taken branch accepted in RUN or FLUSH, saturating. Both clear on reset.
- When undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset held 2 cycles, then released with all inputs 0 → state=0, pc_write=1, if_id_write=1, mem_err=0.
- ex_memread=1, ex_rd=5, id_rs1=5, id_valid=1 for 1 cycle → exactly one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1. Repeat with ex_rd=0 → no stall.
- ex_branch_taken pulse with BRANCH_PENALTY=2 → if_id_flush=1 for 2 consecutive cycles, state 0→2→0, pc_write=1 throughout.
- Same cycle: mem_req=1, mem_ready=0, ex_branch_taken=1, lu true → freeze only: hold=1, flush=0. mem_ready rises after 3 cycles → state returns to 0 on the following edge.
- MEM_TIMEOUT=4, mem_ready held 0 → mem_err rises on the 4th wait cycle and stays 1 after mem_ready; it clears only on reset.
- With HAZARD_PERF_EN: one load-use stall plus 3 wait cycles → stall_cycles=4; two taken branches → flush_events=2.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: load-use bubbles, branch flushes, data-memory waits.
// Optional HAZARD_PERF_EN adds stall_cycles / flush_events performance counters.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | normal issue; memory wait, taken branch or load-use evaluated
// ST_MEMW  | data memory busy; pipeline frozen until mem_ready
// ST_FLUSH | post-branch shadow; IF/ID flushed until flush counter expires
// ST_BAD   | unused encoding; returns to ST_RUN
module pipe_hazard_ctrl #(
    parameter int BRANCH_PENALTY = 2,
    parameter int MEM_TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_memread,
    input  logic       ex_branch_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_bubble,
    output logic       ex_mem_hold,
    output logic       mem_err,
    output logic [1:0] state
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MEMW  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(BRANCH_PENALTY - 1);
    localparam logic [7:0] TIMEOUT    = 8'(MEM_TIMEOUT);

    state_t     r_state;
    logic [2:0] r_flush_cnt;
    logic [7:0] r_wait_cnt;
    logic       r_mem_err;

    state_t     w_next_state;
    logic [2:0] w_flush_cnt_nxt;
    logic [7:0] w_wait_cnt_nxt;
    logic [7:0] w_wait_inc;
    logic       w_lu;
    logic       w_mem_wait;
    logic       w_branch_acc;
    logic       w_err_set;

    assign w_lu = id_valid & ex_memread & (ex_rd != 5'd0) &
                  ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
    assign w_mem_wait = mem_req & ~mem_ready;
    assign w_wait_inc = (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;

    always_comb begin
        w_next_state    = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_wait_cnt_nxt  = 8'd0;
        w_branch_acc    = 1'b0;
        pc_write        = 1'b1;
        if_id_write     = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_bubble    = 1'b0;
        ex_mem_hold     = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_mem_wait) begin
                    pc_write       = 1'b0;
                    if_id_write    = 1'b0;
                    ex_mem_hold    = 1'b1;
                    w_next_state   = ST_MEMW;
                    w_wait_cnt_nxt = 8'd1;
                end else if (ex_branch_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    w_branch_acc = 1'b1;
                    if (BRANCH_PENALTY > 1) begin
                        w_next_state    = ST_FLUSH;
                        w_flush_cnt_nxt = FLUSH_INIT;
                    end
                end else if (w_lu) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
            ST_MEMW: begin
                // branch/load-use inputs are frozen here and re-evaluated once back in RUN
                if (!mem_ready) begin
                    pc_write       = 1'b0;
                    if_id_write    = 1'b0;
                    ex_mem_hold    = 1'b1;
                    w_wait_cnt_nxt = w_wait_inc;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                if (w_mem_wait) begin
                    pc_write       = 1'b0;
                    if_id_write    = 1'b0;
                    ex_mem_hold    = 1'b1;
                    w_wait_cnt_nxt = w_wait_inc;
                end else if (ex_branch_taken) begin
                    w_branch_acc    = 1'b1;
                    w_flush_cnt_nxt = FLUSH_INIT;
                end else if (r_flush_cnt <= 3'd1) begin
                    w_next_state    = ST_RUN;
                    w_flush_cnt_nxt = 3'd0;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                end
            end
            default: begin
                w_next_state    = ST_RUN;
                w_flush_cnt_nxt = 3'd0;
            end
        endcase

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_hold  = 1'b0;
        end
    end

    assign w_err_set = (w_wait_cnt_nxt >= TIMEOUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 3'd0;
            r_wait_cnt  <= 8'd0;
            r_mem_err   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            if (w_err_set) r_mem_err <= 1'b1;
        end
    end

    assign mem_err = r_mem_err;
    assign state   = r_state;

`ifdef HAZARD_PERF_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_events;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= 16'd0;
            r_flush_events <= 16'd0;
        end else begin
            if (!pc_write && r_stall_cycles != 16'hFFFF)
                r_stall_cycles <= r_stall_cycles + 16'd1;
            if (w_branch_acc && r_flush_events != 16'hFFFF)
                r_flush_events <= r_flush_events + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (BRANCH_PENALTY=2, MEM_TIMEOUT=4).
// Inputs change and outputs are sampled in the low clock phase.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_memread;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       ex_mem_hold;
    logic       mem_err;
    logic [1:0] state;
`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;
`endif

    int n_vec = 0;
    int n_err = 0;

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold}
    logic [4:0] outs;
    assign outs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold};

    localparam logic [4:0] O_DEF   = 5'b11000;
    localparam logic [4:0] O_RST   = 5'b00110;
    localparam logic [4:0] O_LU    = 5'b00010;
    localparam logic [4:0] O_BR    = 5'b11110;
    localparam logic [4:0] O_FRZ   = 5'b00001;
    localparam logic [4:0] O_FRZFL = 5'b00111;

    pipe_hazard_ctrl #(
        .BRANCH_PENALTY(2),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .id_valid(id_valid),
        .id_rs1(id_rs1),
        .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd),
        .ex_memread(ex_memread),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req),
        .mem_ready(mem_ready),
        .pc_write(pc_write),
        .if_id_write(if_id_write),
        .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble),
        .ex_mem_hold(ex_mem_hold),
        .mem_err(mem_err),
        .state(state)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_in();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0;
        ex_rd = 0; ex_memread = 0; ex_branch_taken = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_in();
        tick(); tick();
        #1;
        n_vec++;
        if (outs !== O_RST) begin n_err++; $display("FAIL reset_outs got=%b exp=%b", outs, O_RST); end
        reset = 1'b0;
        #1;
        n_vec++;
        if (state !== 2'd0 || outs !== O_DEF || mem_err !== 1'b0) begin
            n_err++; $display("FAIL reset_release state=%0d outs=%b err=%b exp=0/%b/0", state, outs, mem_err, O_DEF);
        end
        tick();
    endtask

    task automatic test_load_use();
        id_valid = 1; ex_memread = 1; ex_rd = 5'd5; id_rs1 = 5'd5;
        #1;
        n_vec++;
        if (outs !== O_LU || state !== 2'd0) begin n_err++; $display("FAIL lu_rs1 outs=%b state=%0d exp=%b/0", outs, state, O_LU); end
        tick();
        clear_in();
        #1;
        n_vec++;
        if (outs !== O_DEF || state !== 2'd0) begin n_err++; $display("FAIL lu_one_bubble outs=%b state=%0d exp=%b/0", outs, state, O_DEF); end
        tick();
        id_valid = 1; ex_memread = 1; ex_rd = 5'd0; id_rs1 = 5'd0;
        #1;
        n_vec++;
        if (outs !== O_DEF) begin n_err++; $display("FAIL lu_rd0 outs=%b exp=%b", outs, O_DEF); end
        tick();
        id_valid = 1; ex_memread = 1; ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_uses_rs2 = 1;
        #1;
        n_vec++;
        if (outs !== O_LU) begin n_err++; $display("FAIL lu_rs2 outs=%b exp=%b", outs, O_LU); end
        tick();
        id_uses_rs2 = 0;
        #1;
        n_vec++;
        if (outs !== O_DEF) begin n_err++; $display("FAIL lu_rs2_unused outs=%b exp=%b", outs, O_DEF); end
        tick();
        id_uses_rs2 = 1; id_valid = 0;
        #1;
        n_vec++;
        if (outs !== O_DEF) begin n_err++; $display("FAIL lu_invalid outs=%b exp=%b", outs, O_DEF); end
        tick();
        id_valid = 1; ex_memread = 0;
        #1;
        n_vec++;
        if (outs !== O_DEF) begin n_err++; $display("FAIL lu_not_load outs=%b exp=%b", outs, O_DEF); end
        tick();
        clear_in();
    endtask

    task automatic test_branch();
        ex_branch_taken = 1;
        #1;
        n_vec++;
        if (outs !== O_BR || state !== 2'd0) begin n_err++; $display("FAIL br_cycle1 outs=%b state=%0d exp=%b/0", outs, state, O_BR); end
        tick();
        ex_branch_taken = 0;
        #1;
        n_vec++;
        if (outs !== O_BR || state !== 2'd2) begin n_err++; $display("FAIL br_cycle2 outs=%b state=%0d exp=%b/2", outs, state, O_BR); end
        tick();
        #1;
        n_vec++;
        if (outs !== O_DEF || state !== 2'd0) begin n_err++; $display("FAIL br_done outs=%b state=%0d exp=%b/0", outs, state, O_DEF); end
        // second branch while in FLUSH reloads the shadow
        ex_branch_taken = 1;
        tick();
        #1;
        n_vec++;
        if (outs !== O_BR || state !== 2'd2) begin n_err++; $display("FAIL br_reload_in outs=%b state=%0d exp=%b/2", outs, state, O_BR); end
        tick();
        ex_branch_taken = 0;
        #1;
        n_vec++;
        if (outs !== O_BR || state !== 2'd2) begin n_err++; $display("FAIL br_reload_hold outs=%b state=%0d exp=%b/2", outs, state, O_BR); end
        tick();
        #1;
        n_vec++;
        if (outs !== O_DEF || state !== 2'd0) begin n_err++; $display("FAIL br_reload_done outs=%b state=%0d exp=%b/0", outs, state, O_DEF); end
        tick();
    endtask

    task automatic test_priority();
        mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
        id_valid = 1; ex_memread = 1; ex_rd = 5'd9; id_rs1 = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (outs !== O_FRZ || state !== ((i == 0) ? 2'd0 : 2'd1)) begin
                n_err++; $display("FAIL prio_freeze%0d outs=%b state=%0d exp=%b", i, outs, state, O_FRZ);
            end
            tick();
        end
        mem_ready = 1;
        #1;
        n_vec++;
        if (outs !== O_DEF || state !== 2'd1) begin n_err++; $display("FAIL prio_ready outs=%b state=%0d exp=%b/1", outs, state, O_DEF); end
        tick();
        clear_in();
        #1;
        n_vec++;
        if (state !== 2'd0 || mem_err !== 1'b0) begin n_err++; $display("FAIL prio_back_run state=%0d err=%b exp=0/0", state, mem_err); end
        tick();
    endtask

    task automatic test_mem_timeout();
        mem_req = 1; mem_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_vec++;
            if (mem_err !== 1'b0 || outs !== O_FRZ) begin
                n_err++; $display("FAIL tmo_wait%0d err=%b outs=%b exp=0/%b", i, mem_err, outs, O_FRZ);
            end
            tick();
        end
        #1;
        n_vec++;
        if (mem_err !== 1'b1 || outs !== O_FRZ || state !== 2'd1) begin
            n_err++; $display("FAIL tmo_set err=%b outs=%b state=%0d exp=1/%b/1", mem_err, outs, state, O_FRZ);
        end
        tick();
        mem_ready = 1;
        tick();
        clear_in();
        #1;
        n_vec++;
        if (mem_err !== 1'b1 || state !== 2'd0) begin n_err++; $display("FAIL tmo_sticky err=%b state=%0d exp=1/0", mem_err, state); end
        tick(); tick();
        n_vec++;
        if (mem_err !== 1'b1) begin n_err++; $display("FAIL tmo_sticky2 err=%b exp=1", mem_err); end
        reset = 1;
        tick();
        reset = 0;
        #1;
        n_vec++;
        if (mem_err !== 1'b0) begin n_err++; $display("FAIL tmo_clear err=%b exp=0", mem_err); end
        tick();
    endtask

    task automatic test_flush_memwait();
        ex_branch_taken = 1;
        tick();
        ex_branch_taken = 0; mem_req = 1; mem_ready = 0;
        #1;
        n_vec++;
        if (outs !== O_FRZFL || state !== 2'd2) begin n_err++; $display("FAIL flw_freeze outs=%b state=%0d exp=%b/2", outs, state, O_FRZFL); end
        tick();
        #1;
        n_vec++;
        if (outs !== O_FRZFL || state !== 2'd2) begin n_err++; $display("FAIL flw_hold outs=%b state=%0d exp=%b/2", outs, state, O_FRZFL); end
        tick();
        mem_ready = 1;
        #1;
        n_vec++;
        if (outs !== O_BR || state !== 2'd2) begin n_err++; $display("FAIL flw_resume outs=%b state=%0d exp=%b/2", outs, state, O_BR); end
        tick();
        clear_in();
        #1;
        n_vec++;
        if (outs !== O_DEF || state !== 2'd0) begin n_err++; $display("FAIL flw_done outs=%b state=%0d exp=%b/0", outs, state, O_DEF); end
        tick();
    endtask

    task automatic test_reset_abort();
        ex_branch_taken = 1;
        tick();
        ex_branch_taken = 0;
        reset = 1;
        #1;
        n_vec++;
        if (outs !== O_RST) begin n_err++; $display("FAIL abort_rst_outs outs=%b exp=%b", outs, O_RST); end
        tick();
        reset = 0;
        #1;
        n_vec++;
        if (outs !== O_DEF || state !== 2'd0) begin n_err++; $display("FAIL abort_flush outs=%b state=%0d exp=%b/0", outs, state, O_DEF); end
        tick();
        mem_req = 1;
        tick(); tick();
        reset = 1;
        tick();
        reset = 0; clear_in();
        #1;
        n_vec++;
        if (outs !== O_DEF || state !== 2'd0) begin n_err++; $display("FAIL abort_memw outs=%b state=%0d exp=%b/0", outs, state, O_DEF); end
        tick();
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        reset = 1;
        tick();
        reset = 0;
        id_valid = 1; ex_memread = 1; ex_rd = 5'd4; id_rs1 = 5'd4;
        tick();
        clear_in();
        mem_req = 1;
        tick(); tick(); tick();
        mem_ready = 1;
        tick();
        clear_in();
        #1;
        n_vec++;
        if (stall_cycles !== 16'd4) begin n_err++; $display("FAIL perf_stall got=%0d exp=4", stall_cycles); end
        for (int b = 0; b < 2; b++) begin
            ex_branch_taken = 1;
            tick();
            ex_branch_taken = 0;
            tick(); tick();
        end
        #1;
        n_vec++;
        if (flush_events !== 16'd2 || stall_cycles !== 16'd4) begin
            n_err++; $display("FAIL perf_flush events=%0d stall=%0d exp=2/4", flush_events, stall_cycles);
        end
        tick();
    endtask
`endif

    initial begin
        clear_in();
        reset = 1;
        tick();
        test_reset();
        test_load_use();
        test_branch();
        test_priority();
        test_mem_timeout();
        test_flush_memwait();
        test_reset_abort();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
